// File: rtl/i2c_slave_bus_detect_block_pkg.sv
// Shared definitions for the I2C slave bus detector: FSM state encoding,
// byte width and the default glitch-filter length.
package i2c_slave_bus_detect_block_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_ACK  = 2'd2
    } detect_state_t;

    localparam logic [3:0] I2C_BYTE_BITS      = 4'd8;
    localparam int unsigned DEFAULT_FILTER_LEN = 3;

endpackage

// File: rtl/i2c_slave_bus_detect_block_line_filter.sv
// Conditions one raw bus line: 2-flop synchroniser followed by a 4-bit
// persistence counter. The filtered value only follows the synchronised
// value after it has differed for FILTER_LEN consecutive clocks.
// Ports:
//   clk       core clock, rising edge
//   rst       synchronous active-high reset (line resets to idle-high)
//   line_raw  asynchronous pad input
//   line_filt filtered, registered line value
module i2c_slave_bus_detect_block_line_filter
    import i2c_slave_bus_detect_block_pkg::*;
#(
    parameter int unsigned FILTER_LEN = DEFAULT_FILTER_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic line_raw,
    output logic line_filt
);

    // Toggle happens on the clock where the counter would reach FILTER_LEN,
    // so total raw-to-filtered latency is 2 + FILTER_LEN clocks.
    localparam logic [3:0] CNT_LAST = 4'(FILTER_LEN - 1);

    logic       sync1_r;
    logic       sync2_r;
    logic       filt_r;
    logic [3:0] cnt_r;
    logic       filt_n_s;
    logic [3:0] cnt_n_s;

    // Persistence counter next-state
    always_comb begin
        filt_n_s = filt_r;
        cnt_n_s  = 4'd0;
        if (sync2_r != filt_r) begin
            if (cnt_r == CNT_LAST) begin
                filt_n_s = ~filt_r;
                cnt_n_s  = 4'd0;
            end else begin
                filt_n_s = filt_r;
                cnt_n_s  = cnt_r + 4'd1;
            end
        end else begin
            filt_n_s = filt_r;
            cnt_n_s  = 4'd0;
        end
    end

    // Synchroniser, filter counter and filtered value registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            filt_r  <= 1'b1;
            cnt_r   <= 4'd0;
        end else begin
            sync1_r <= line_raw;
            sync2_r <= sync1_r;
            filt_r  <= filt_n_s;
            cnt_r   <= cnt_n_s;
        end
    end

    assign line_filt = filt_r;

endmodule

// File: rtl/i2c_slave_bus_detect_block.sv
// I2C slave bus detector: filters SCL/SDA, reports SCL edges and
// START/STOP conditions, shifts in bytes MSB-first and flags the ACK clock.
// Ports:
//   i2c_core_clock_i  core clock          reset_bit_i  sync active-high reset
//   enable_i          detector enable     scl_i/sda_i  raw pad lines
//   scl_o/sda_o       filtered lines      scl_rise_o/scl_fall_o  SCL edge pulses
//   start_o/stop_o    bus condition pulses bus_busy_o  START..STOP window
//   rx_data_o         last complete byte  rx_valid_o   byte-complete pulse
//   bit_count_o       bits of current byte ack_phase_o 9th clock flag
module i2c_slave_bus_detect_block
    import i2c_slave_bus_detect_block_pkg::*;
#(
    parameter int unsigned FILTER_LEN = DEFAULT_FILTER_LEN
) (
    input  logic       i2c_core_clock_i,
    input  logic       reset_bit_i,
    input  logic       enable_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_o,
    output logic       sda_o,
    output logic       scl_rise_o,
    output logic       scl_fall_o,
    output logic       start_o,
    output logic       stop_o,
    output logic       bus_busy_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic [3:0] bit_count_o,
    output logic       ack_phase_o
);

    logic          scl_f_s;
    logic          sda_f_s;
    logic          scl_d_r;
    logic          sda_d_r;
    logic          rise_s;
    logic          fall_s;
    logic          start_s;
    logic          stop_s;

    detect_state_t state_r,   state_n_s;
    logic          busy_r,    busy_n_s;
    logic [3:0]    cnt_r,     cnt_n_s;
    logic [7:0]    shift_r,   shift_n_s;
    logic [7:0]    rx_data_r, rx_data_n_s;
    logic          valid_r,   valid_n_s;
    logic          ack_r,     ack_n_s;

    i2c_slave_bus_detect_block_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk       (i2c_core_clock_i),
        .rst       (reset_bit_i),
        .line_raw  (scl_i),
        .line_filt (scl_f_s)
    );

    i2c_slave_bus_detect_block_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk       (i2c_core_clock_i),
        .rst       (reset_bit_i),
        .line_raw  (sda_i),
        .line_filt (sda_f_s)
    );

    // Edge/condition detection needs both SCL samples high, so an SDA change
    // coincident with an SCL edge never reads as START or STOP.
    assign rise_s  = enable_i &  scl_f_s & ~scl_d_r;
    assign fall_s  = enable_i & ~scl_f_s &  scl_d_r;
    assign start_s = enable_i &  sda_d_r & ~sda_f_s & scl_f_s & scl_d_r;
    assign stop_s  = enable_i & ~sda_d_r &  sda_f_s & scl_f_s & scl_d_r;

    // FSM next-state, shift register and byte-complete logic
    always_comb begin
        state_n_s   = state_r;
        busy_n_s    = busy_r;
        cnt_n_s     = cnt_r;
        shift_n_s   = shift_r;
        rx_data_n_s = rx_data_r;
        valid_n_s   = 1'b0;
        ack_n_s     = ack_r;
        if (!enable_i) begin
            state_n_s = ST_IDLE;
            busy_n_s  = 1'b0;
            cnt_n_s   = 4'd0;
            ack_n_s   = 1'b0;
        end else if (start_s) begin
            // Also covers repeated START mid-byte or mid-ACK
            state_n_s = ST_RECV;
            busy_n_s  = 1'b1;
            cnt_n_s   = 4'd0;
            shift_n_s = 8'h00;
            ack_n_s   = 1'b0;
        end else if (stop_s) begin
            state_n_s = ST_IDLE;
            busy_n_s  = 1'b0;
            cnt_n_s   = 4'd0;
            ack_n_s   = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_n_s = ST_IDLE;
                end
                ST_RECV: begin
                    if (rise_s && (cnt_r < I2C_BYTE_BITS)) begin
                        shift_n_s = {shift_r[6:0], sda_f_s};
                        cnt_n_s   = cnt_r + 4'd1;
                        if (cnt_r == (I2C_BYTE_BITS - 4'd1)) begin
                            rx_data_n_s = {shift_r[6:0], sda_f_s};
                            valid_n_s   = 1'b1;
                        end else begin
                            valid_n_s   = 1'b0;
                        end
                    end else if (fall_s && (cnt_r == I2C_BYTE_BITS)) begin
                        state_n_s = ST_ACK;
                        ack_n_s   = 1'b1;
                    end else begin
                        state_n_s = ST_RECV;
                    end
                end
                ST_ACK: begin
                    if (fall_s) begin
                        state_n_s = ST_RECV;
                        ack_n_s   = 1'b0;
                        cnt_n_s   = 4'd0;
                    end else begin
                        state_n_s = ST_ACK;
                    end
                end
                default: begin
                    state_n_s = ST_IDLE;
                    busy_n_s  = 1'b0;
                    cnt_n_s   = 4'd0;
                    ack_n_s   = 1'b0;
                end
            endcase
        end
    end

    // State, datapath and delayed-line registers
    always_ff @(posedge i2c_core_clock_i) begin
        if (reset_bit_i) begin
            scl_d_r   <= 1'b1;
            sda_d_r   <= 1'b1;
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
            cnt_r     <= 4'd0;
            shift_r   <= 8'h00;
            rx_data_r <= 8'h00;
            valid_r   <= 1'b0;
            ack_r     <= 1'b0;
        end else begin
            scl_d_r   <= scl_f_s;
            sda_d_r   <= sda_f_s;
            state_r   <= state_n_s;
            busy_r    <= busy_n_s;
            cnt_r     <= cnt_n_s;
            shift_r   <= shift_n_s;
            rx_data_r <= rx_data_n_s;
            valid_r   <= valid_n_s;
            ack_r     <= ack_n_s;
        end
    end

    assign scl_o       = scl_f_s;
    assign sda_o       = sda_f_s;
    assign scl_rise_o  = rise_s;
    assign scl_fall_o  = fall_s;
    assign start_o     = start_s;
    assign stop_o      = stop_s;
    assign bus_busy_o  = busy_r;
    assign rx_data_o   = rx_data_r;
    assign rx_valid_o  = valid_r & enable_i;
    assign bit_count_o = cnt_r;
    assign ack_phase_o = ack_r;

endmodule

// File: tb/tb_i2c_slave_bus_detect_block.sv
// Directed bench for i2c_slave_bus_detect_block (FILTER_LEN = 3).
// Received bytes are checked against a queue of expected bytes; event
// pulses are counted on the falling clock edge and compared as deltas.
module tb_i2c_slave_bus_detect_block;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b1;
    logic       scl = 1'b1;
    logic       sda = 1'b1;
    logic       scl_o, sda_o, scl_rise, scl_fall, start_p, stop_p, busy;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [3:0] bit_cnt;
    logic       ack;

    int n_pass  = 0;
    int n_total = 0;
    int c_rise = 0, c_fall = 0, c_start = 0, c_stop = 0, c_valid = 0;
    int s_rise, s_fall, s_start, s_stop, s_valid;
    logic [7:0] exp_q[$];

    i2c_slave_bus_detect_block #(.FILTER_LEN(3)) dut (
        .i2c_core_clock_i (clk),
        .reset_bit_i      (rst),
        .enable_i         (en),
        .scl_i            (scl),
        .sda_i            (sda),
        .scl_o            (scl_o),
        .sda_o            (sda_o),
        .scl_rise_o       (scl_rise),
        .scl_fall_o       (scl_fall),
        .start_o          (start_p),
        .stop_o           (stop_p),
        .bus_busy_o       (busy),
        .rx_data_o        (rx_data),
        .rx_valid_o       (rx_valid),
        .bit_count_o      (bit_cnt),
        .ack_phase_o      (ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Pulse counters and rx scoreboard, sampled away from the active edge
    always @(negedge clk) begin
        if (scl_rise) c_rise++;
        if (scl_fall) c_fall++;
        if (start_p)  c_start++;
        if (stop_p)   c_stop++;
        if (rx_valid) begin
            c_valid++;
            if (exp_q.size() == 0) begin
                check("rx_unexpected", {24'd0, rx_data}, 32'hFFFF_FFFF);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("rx_data", {24'd0, rx_data}, {24'd0, e});
                check("rx_bitcnt", {28'd0, bit_cnt}, 32'd8);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        s_rise = c_rise; s_fall = c_fall; s_start = c_start;
        s_stop = c_stop; s_valid = c_valid;
    endtask

    task automatic send_bit(input logic b);
        scl = 1'b0; tick(10);
        sda = b;    tick(10);
        scl = 1'b1; tick(20);
    endtask

    task automatic send_start();
        sda = 1'b0; tick(20);
    endtask

    initial begin
        logic [7:0] byte_v;

        // Reset with idle-high lines
        tick(3);
        rst = 1'b0;
        tick(1);
        check("rst_scl", {31'd0, scl_o}, 32'd1);
        check("rst_sda", {31'd0, sda_o}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rxdata", {24'd0, rx_data}, 32'd0);
        check("rst_bitcnt", {28'd0, bit_cnt}, 32'd0);
        check("rst_pulses", {26'd0, scl_rise, scl_fall, start_p, stop_p, rx_valid, ack}, 32'd0);

        // Filter latency: exactly 5 clocks raw-to-filtered
        scl = 1'b0;
        tick(4);
        check("lat_t4_scl", {31'd0, scl_o}, 32'd1);
        tick(1);
        check("lat_t5_scl", {31'd0, scl_o}, 32'd0);
        check("lat_t5_fall", {31'd0, scl_fall}, 32'd1);
        scl = 1'b1;
        tick(10);
        check("lat_back_high", {31'd0, scl_o}, 32'd1);

        // 2-cycle glitch is rejected
        snap();
        scl = 1'b0; tick(2);
        scl = 1'b1; tick(10);
        check("glitch_fall", c_fall - s_fall, 32'd0);
        check("glitch_rise", c_rise - s_rise, 32'd0);
        check("glitch_scl", {31'd0, scl_o}, 32'd1);

        // START + byte A5 + ACK clock
        snap();
        send_start();
        check("start_busy", {31'd0, busy}, 32'd1);
        check("start_bitcnt", {28'd0, bit_cnt}, 32'd0);
        byte_v = 8'hA5;
        exp_q.push_back(8'hA5);
        for (int i = 7; i >= 0; i--) send_bit(byte_v[i]);
        check("byte_ack_before", {31'd0, ack}, 32'd0);
        scl = 1'b0; tick(10);
        check("byte_ack_8fall", {31'd0, ack}, 32'd1);
        check("byte_bitcnt_ack", {28'd0, bit_cnt}, 32'd8);
        sda = 1'b0; tick(10);
        scl = 1'b1; tick(20);
        check("byte_ack_9high", {31'd0, ack}, 32'd1);
        scl = 1'b0; tick(10);
        check("byte_ack_9fall", {31'd0, ack}, 32'd0);
        check("byte_bitcnt_end", {28'd0, bit_cnt}, 32'd0);
        check("byte_starts", c_start - s_start, 32'd1);
        check("byte_valids", c_valid - s_valid, 32'd1);
        check("byte_hold", {24'd0, rx_data}, 32'hA5);

        // STOP: SDA rises while SCL high
        snap();
        scl = 1'b1; tick(20);
        sda = 1'b1; tick(20);
        check("stop_count", c_stop - s_stop, 32'd1);
        check("stop_busy", {31'd0, busy}, 32'd0);
        check("stop_bitcnt", {28'd0, bit_cnt}, 32'd0);
        send_bit(1'b1);
        check("idle_ignores_scl", {28'd0, bit_cnt}, 32'd0);

        // START, 4 bits, repeated START
        snap();
        send_start();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        check("rs_bitcnt4", {28'd0, bit_cnt}, 32'd4);
        scl = 1'b0; tick(10);
        sda = 1'b1; tick(10);
        scl = 1'b1; tick(20);
        send_start();
        check("rs_starts", c_start - s_start, 32'd2);
        check("rs_bitcnt", {28'd0, bit_cnt}, 32'd0);
        check("rs_busy", {31'd0, busy}, 32'd1);
        check("rs_valids", c_valid - s_valid, 32'd0);

        // SCL and SDA changing in the same cycle: no START/STOP
        snap();
        scl = 1'b0; sda = 1'b1; tick(20);
        scl = 1'b1; sda = 1'b0; tick(20);
        check("simul_starts", c_start - s_start, 32'd0);
        check("simul_stops", c_stop - s_stop, 32'd0);
        check("simul_busy", {31'd0, busy}, 32'd1);
        sda = 1'b1; tick(20);
        check("simul_then_stop", c_stop - s_stop, 32'd1);

        // Reset mid-byte
        snap();
        send_start();
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        check("rst_mid_bitcnt5", {28'd0, bit_cnt}, 32'd5);
        rst = 1'b1; scl = 1'b1; sda = 1'b1;
        tick(1);
        check("rst_mid_bitcnt", {28'd0, bit_cnt}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        tick(20);
        check("rst_mid_valids", c_valid - s_valid, 32'd0);

        // Enable dropped during a byte
        send_start();
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        en = 1'b0;
        tick(1);
        check("en_busy", {31'd0, busy}, 32'd0);
        check("en_bitcnt", {28'd0, bit_cnt}, 32'd0);
        snap();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        sda = 1'b1; tick(20);
        check("en_events", (c_rise - s_rise) + (c_fall - s_fall) + (c_start - s_start)
                           + (c_stop - s_stop) + (c_valid - s_valid), 32'd0);
        check("en_scl_filtered", {31'd0, scl_o}, 32'd1);
        en = 1'b1;
        tick(5);
        check("en_back_busy", {31'd0, busy}, 32'd0);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
